// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

   localparam int unsigned DIV_W_DEF = 8;

   typedef logic [DIV_W_DEF-1:0] div_t;

   typedef struct packed {
      div_t cnt;
      div_t active;
      div_t pending;
      logic pend;
   } ch_state_t;

   // ceil(a/2) with one extra bit so the all-ones ratio cannot overflow
   function automatic logic [DIV_W_DEF:0] half_ceil(input div_t a);
      return ({1'b0, a} + (DIV_W_DEF+1)'(1)) >> 1;
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, deferred ratio load, bit-slip and registered
// square-wave / clock-enable outputs.
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter div_t DEFAULT_DIV = DIV_W_DEF'(4)
) (
   input  logic CLK_IN,
   input  logic RESET_N,
   input  logic SRESET,
   input  div_t div_value,
   input  logic div_load,
   input  logic bitslip,
   output logic clk_out,
   output logic ce_out,
   output div_t div_active,
   output logic load_pend
);

   ch_state_t st_q, st_d;
   logic      run_q, run_d;
   logic      clk_q, clk_d;
   logic      ce_q, ce_d;
   logic      wrap;
   logic      slip;

   // run_q idles the first edge after reset so the first pulse lands on the second edge
   always_comb begin
      st_d  = st_q;
      run_d = 1'b1;
      clk_d = 1'b0;
      ce_d  = 1'b0;
      wrap  = (st_q.active != '0) && (st_q.cnt == st_q.active - DIV_W_DEF'(1));
      slip  = bitslip && (st_q.active > DIV_W_DEF'(1));
      if (run_q) begin
         ce_d  = (st_q.active != '0) && (st_q.cnt == '0);
         clk_d = (st_q.active != '0) && ({1'b0, st_q.cnt} < half_ceil(st_q.active));
         if (SRESET || (st_q.active == '0) || (wrap && !slip)) begin
            st_d.cnt = '0;
            if (st_q.pend) begin
               st_d.active = st_q.pending;
               st_d.pend   = 1'b0;
            end
         end else if (!slip) begin
            st_d.cnt = st_q.cnt + DIV_W_DEF'(1);
         end
      end
      // a load on the apply edge is only captured; it waits for the next boundary
      if (div_load) begin
         st_d.pending = div_value;
         st_d.pend    = 1'b1;
      end
   end

   always_ff @(posedge CLK_IN) begin
      if (!RESET_N) begin
         st_q  <= '{cnt: '0, active: DEFAULT_DIV, pending: '0, pend: 1'b0};
         run_q <= 1'b0;
         clk_q <= 1'b0;
         ce_q  <= 1'b0;
      end else begin
         st_q  <= st_d;
         run_q <= run_d;
         clk_q <= clk_d;
         ce_q  <= ce_d;
      end
   end

   assign clk_out    = clk_q;
   assign ce_out     = ce_q;
   assign div_active = st_q.active;
   assign load_pend  = st_q.pend;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider; one clk_div_channel per lane.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned DIV_W       = DIV_W_DEF,
   parameter int unsigned DEFAULT_DIV = 4
) (
   input  logic                    CLK_IN,
   input  logic                    RESET_N,
   input  logic [NUM_CH*DIV_W-1:0] DIV_VALUE,
   input  logic [NUM_CH-1:0]       DIV_LOAD,
   input  logic [NUM_CH-1:0]       BITSLIP,
   input  logic                    SRESET,
   output logic [NUM_CH-1:0]       CLK_OUT,
   output logic [NUM_CH-1:0]       CE_OUT,
   output logic [NUM_CH*DIV_W-1:0] DIV_ACTIVE,
   output logic [NUM_CH-1:0]       LOAD_PEND
);

   // DIV_W must match the package channel width
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_channel #(
         .DEFAULT_DIV (DIV_W_DEF'(DEFAULT_DIV))
      ) u_ch (
         .CLK_IN     (CLK_IN),
         .RESET_N    (RESET_N),
         .SRESET     (SRESET),
         .div_value  (DIV_VALUE[i*DIV_W +: DIV_W]),
         .div_load   (DIV_LOAD[i]),
         .bitslip    (BITSLIP[i]),
         .clk_out    (CLK_OUT[i]),
         .ce_out     (CE_OUT[i]),
         .div_active (DIV_ACTIVE[i*DIV_W +: DIV_W]),
         .load_pend  (LOAD_PEND[i])
      );
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: cycle scoreboard plus ratio table and directed corner cases.
module tb_clk_div_multi;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned DIV_W  = 8;

   logic                    CLK_IN;
   logic                    RESET_N;
   logic [NUM_CH*DIV_W-1:0] DIV_VALUE;
   logic [NUM_CH-1:0]       DIV_LOAD;
   logic [NUM_CH-1:0]       BITSLIP;
   logic                    SRESET;
   logic [NUM_CH-1:0]       CLK_OUT;
   logic [NUM_CH-1:0]       CE_OUT;
   logic [NUM_CH*DIV_W-1:0] DIV_ACTIVE;
   logic [NUM_CH-1:0]       LOAD_PEND;

   clk_div_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(4)) dut (
      .CLK_IN     (CLK_IN),
      .RESET_N    (RESET_N),
      .DIV_VALUE  (DIV_VALUE),
      .DIV_LOAD   (DIV_LOAD),
      .BITSLIP    (BITSLIP),
      .SRESET     (SRESET),
      .CLK_OUT    (CLK_OUT),
      .CE_OUT     (CE_OUT),
      .DIV_ACTIVE (DIV_ACTIVE),
      .LOAD_PEND  (LOAD_PEND)
   );

   initial CLK_IN = 1'b0;
   always #5 CLK_IN = ~CLK_IN;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int m_cnt [NUM_CH];
   int m_a   [NUM_CH];
   int m_p   [NUM_CH];
   bit m_pend[NUM_CH];
   bit m_run [NUM_CH];

   typedef struct packed {
      logic [NUM_CH-1:0]       clk;
      logic [NUM_CH-1:0]       ce;
      logic [NUM_CH-1:0]       pend;
      logic [NUM_CH*DIV_W-1:0] act;
   } exp_t;

   exp_t sb_q[$];

   typedef struct {
      int ratio;
      int exp_hi;
      int exp_lo;
      int exp_per;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one edge with the currently driven inputs.
   task automatic model_step();
      exp_t e;
      e = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (!RESET_N) begin
            m_cnt[c] = 0; m_a[c] = 4; m_p[c] = 0; m_pend[c] = 0; m_run[c] = 0;
         end else begin
            if (m_run[c]) begin
               e.ce[c]  = (m_a[c] >= 1) && (m_cnt[c] == 0);
               e.clk[c] = (m_a[c] >= 1) && (m_cnt[c] < (m_a[c] + 1) / 2);
            end
            if (!m_run[c]) begin
               m_run[c] = 1;
            end else if (SRESET) begin
               m_cnt[c] = 0;
               if (m_pend[c]) begin m_a[c] = m_p[c]; m_pend[c] = 0; end
            end else if (m_a[c] == 0) begin
               m_cnt[c] = 0;
               if (m_pend[c]) begin m_a[c] = m_p[c]; m_pend[c] = 0; end
            end else if (BITSLIP[c] && m_a[c] > 1) begin
               m_cnt[c] = m_cnt[c];
            end else if (m_cnt[c] == m_a[c] - 1) begin
               m_cnt[c] = 0;
               if (m_pend[c]) begin m_a[c] = m_p[c]; m_pend[c] = 0; end
            end else begin
               m_cnt[c] = m_cnt[c] + 1;
            end
            if (DIV_LOAD[c]) begin
               m_p[c]    = int'(DIV_VALUE[c*DIV_W +: DIV_W]);
               m_pend[c] = 1;
            end
         end
         e.act[c*DIV_W +: DIV_W] = DIV_W'(m_a[c]);
         e.pend[c]               = m_pend[c];
      end
      sb_q.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      exp_t got;
      model_step();
      @(posedge CLK_IN);
      #1;
      e   = sb_q.pop_front();
      got = {CLK_OUT, CE_OUT, LOAD_PEND, DIV_ACTIVE};
      chk("scoreboard", 64'(got), 64'(e));
      DIV_LOAD = '0;
      BITSLIP  = '0;
      SRESET   = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_ce8;
      logic [7:0] exp_clk8;
      logic [4:0] exp_clk5;
      logic       ce_w [600];
      logic       clk_w[600];
      int         len, i1, hi, lo, idx, waited, i2, i3, off;

      vecs[0] = '{2,   1,   1,   2};
      vecs[1] = '{3,   2,   1,   3};
      vecs[2] = '{4,   2,   2,   4};
      vecs[3] = '{5,   3,   2,   5};
      vecs[4] = '{8,   4,   4,   8};
      vecs[5] = '{255, 128, 127, 255};

      RESET_N   = 1'b0;
      DIV_VALUE = '0;
      DIV_LOAD  = '0;
      BITSLIP   = '0;
      SRESET    = 1'b0;
      repeat (3) tick();
      chk("rst_clk",  64'(CLK_OUT),    64'(0));
      chk("rst_ce",   64'(CE_OUT),     64'(0));
      chk("rst_act",  64'(DIV_ACTIVE), 64'(32'h04040404));
      chk("rst_pend", 64'(LOAD_PEND),  64'(0));

      // reset release: first pulse on the second edge, CLK pattern 1100
      exp_ce8  = 8'b0010_0010;
      exp_clk8 = 8'b0110_0110;
      RESET_N  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("rel_ce",  64'(CE_OUT),  64'({NUM_CH{exp_ce8[k]}}));
         chk("rel_clk", 64'(CLK_OUT), 64'({NUM_CH{exp_clk8[k]}}));
      end

      // load 5 on ch0 at cnt==2; current period of 4 completes first
      waited = 0;
      while (m_cnt[0] != 2 && waited < 8) begin tick(); waited++; end
      DIV_VALUE[7:0] = 8'd5;
      DIV_LOAD       = 4'b0001;
      tick();
      chk("ld5_pend", 64'(LOAD_PEND[0]),    64'(1));
      chk("ld5_act0", 64'(DIV_ACTIVE[7:0]), 64'(4));
      waited = 0;
      while (LOAD_PEND[0] && waited < 8) begin tick(); waited++; end
      chk("ld5_wait", 64'(waited),          64'(1));
      chk("ld5_act1", 64'(DIV_ACTIVE[7:0]), 64'(5));
      exp_clk5 = 5'b00111;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("ld5_clk", 64'(CLK_OUT[0]), 64'(exp_clk5[k % 5]));
      end

      // ch1: ratio 0 disables, then ratio 1 passes through
      DIV_VALUE[15:8] = 8'd0;
      DIV_LOAD        = 4'b0010;
      tick();
      waited = 0;
      while (LOAD_PEND[1] && waited < 8) begin tick(); waited++; end
      chk("a0_act", 64'(DIV_ACTIVE[15:8]), 64'(0));
      tick();
      chk("a0_out", 64'({CLK_OUT[1], CE_OUT[1]}), 64'(0));
      DIV_VALUE[15:8] = 8'd1;
      DIV_LOAD        = 4'b0010;
      tick();
      chk("a1_pend", 64'(LOAD_PEND[1]), 64'(1));
      tick();
      chk("a1_act",  64'(DIV_ACTIVE[15:8]), 64'(1));
      chk("a1_pend0", 64'(LOAD_PEND[1]), 64'(0));
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("a1_out", 64'({CLK_OUT[1], CE_OUT[1]}), 64'(2'b11));
      end

      // two slips on ch2 put it 2 cycles behind ch3
      SRESET = 1'b1;
      tick();
      tick();
      tick();
      BITSLIP = 4'b0100;
      tick();
      BITSLIP = 4'b0100;
      tick();
      i2 = -1;
      i3 = -1;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (CE_OUT[2] && i2 < 0) i2 = k;
         if (CE_OUT[3] && i3 < 0) i3 = k;
      end
      off = (((i2 - i3) % 4) + 4) % 4;
      chk("slip_off", 64'(off), 64'(2));

      // SRESET realigns 3/4/6/8 and applies a pending 7 immediately
      DIV_VALUE = {8'd8, 8'd6, 8'd4, 8'd3};
      DIV_LOAD  = 4'hF;
      tick();
      SRESET = 1'b1;
      tick();
      chk("sr_act", 64'(DIV_ACTIVE), 64'(32'h08060403));
      tick();
      chk("sr_ce",  64'(CE_OUT),  64'(4'hF));
      chk("sr_clk", 64'(CLK_OUT), 64'(4'hF));
      DIV_VALUE[31:24] = 8'd7;
      DIV_LOAD         = 4'b1000;
      tick();
      tick();
      chk("sr7_pend", 64'(LOAD_PEND), 64'(4'b1000));
      SRESET = 1'b1;
      tick();
      chk("sr7_act",  64'(DIV_ACTIVE[31:24]), 64'(7));
      chk("sr7_pend0", 64'(LOAD_PEND), 64'(0));
      tick();
      chk("sr7_ce",  64'(CE_OUT),  64'(4'hF));
      chk("sr7_clk", 64'(CLK_OUT), 64'(4'hF));

      // ratio table on ch0: period, high and low lengths
      for (int v = 0; v < 6; v++) begin
         DIV_VALUE[7:0] = 8'(vecs[v].ratio);
         DIV_LOAD       = 4'b0001;
         tick();
         SRESET = 1'b1;
         tick();
         chk("tbl_act", 64'(DIV_ACTIVE[7:0]), 64'(vecs[v].ratio));
         len = 2 * vecs[v].ratio + 4;
         for (int k = 0; k < len; k++) begin
            tick();
            ce_w[k]  = CE_OUT[0];
            clk_w[k] = CLK_OUT[0];
         end
         chk("tbl_ce0", 64'(ce_w[0]), 64'(1));
         i1 = -1;
         for (int k = 1; k < len; k++) if (ce_w[k] && i1 < 0) i1 = k;
         hi  = 0;
         idx = 0;
         while (idx < len && clk_w[idx]) begin hi++; idx++; end
         lo = 0;
         while (idx < len && !clk_w[idx]) begin lo++; idx++; end
         chk("tbl_per", 64'(i1), 64'(vecs[v].exp_per));
         chk("tbl_hi",  64'(hi), 64'(vecs[v].exp_hi));
         chk("tbl_lo",  64'(lo), 64'(vecs[v].exp_lo));
      end

      // reset in the middle of a 255 period
      repeat (50) tick();
      RESET_N = 1'b0;
      tick();
      chk("mid_rst_out", 64'({CLK_OUT, CE_OUT}), 64'(0));
      chk("mid_rst_act", 64'(DIV_ACTIVE), 64'(32'h04040404));
      chk("mid_rst_pnd", 64'(LOAD_PEND), 64'(0));
      RESET_N = 1'b1;

      // random loads, slips and realigns against the model
      for (int k = 0; k < 400; k++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            DIV_VALUE[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 9));
            DIV_LOAD[c] = ($urandom_range(0, 15) == 0);
            BITSLIP[c]  = ($urandom_range(0, 7) == 0);
         end
         SRESET = ($urandom_range(0, 39) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
